regfile_seq_ctrl: RTL
=====================

Name: regfile_seq_ctrl

Overview:
- Control unit (FSM) that sequences the register-file datapath inside the dedicated processor.
- The datapath computes the running sum 0+1+…+LIMIT and publishes each partial sum to the 8-bit outport, which drives the FND display.
- The controller issues register-file read/write addresses, the write-data source select and the outport load strobe. It consumes one comparator flag from the datapath.
- A step-enable input lets one system clock run the processor at display speed (e.g. 10 Hz tick), with no divided clock.

Parameters:
- ADDR_W, 3, register-file address width.
- R_I, 1, register index holding loop counter i.
- R_SUM, 2, register index holding running sum.
- R_ONE, 3, register index holding constant 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- step_en  in  1  advance FSM one state on this cycle; writes/loads only occur when high.
- restart  in  1  leave HALT and rerun program.
- le_flag  in  1  datapath comparator: reg[raddr1] <= LIMIT (combinational from current raddr1).
- raddr1  out  ADDR_W  read port 1 address.
- raddr2  out  ADDR_W  read port 2 address.
- waddr  out  ADDR_W  write address.
- we  out  1  register-file write enable.
- wsel  out  2  write-data source: 00 ALU sum (rd1+rd2), 01 constant 0, 10 constant 1, 11 reserved (never driven).
- out_load  out  1  load outport register from rd1.
- done  out  1  program finished.
- state_dbg  out  3  current state encoding.

Behaviour:
- State register encodings:
  - INIT_I=0, INIT_SUM=1, INIT_ONE=2, CMP=3, ADD=4, INC=5, OUT=6, HALT=7.
  - Reset -> INIT_I.
- Transitions occur only when step_en=1; otherwise the state holds.
- Transition list:
  - INIT_I->INIT_SUM->INIT_ONE->CMP.
  - CMP->ADD if le_flag=1, else HALT.
  - ADD->INC->OUT->CMP.
  - HALT->INIT_I if restart=1 (restart also needs step_en=1), else stay.
  - restart is ignored in every state other than HALT.
- Outputs are a Moore decode of state; we and out_load are additionally ANDed with step_en and forced 0 while reset=1.
- Per-state outputs:
  - INIT_I: waddr=R_I, wsel=01, we.
  - INIT_SUM: waddr=R_SUM, wsel=01, we.
  - INIT_ONE: waddr=R_ONE, wsel=10, we.
  - CMP: raddr1=R_I, no write.
  - ADD: raddr1=R_SUM, raddr2=R_I, waddr=R_SUM, wsel=00, we (sum += i).
  - INC: raddr1=R_I, raddr2=R_ONE, waddr=R_I, wsel=00, we (i += 1).
  - OUT: raddr1=R_SUM, out_load.
  - HALT: raddr1=R_SUM, no write, done=1.
- In states not listed above, address outputs default to 0, wsel=00, we=0, out_load=0.
- done=1 only in HALT; state_dbg=state.
- Reset values: state_dbg=0, done=0, we=0, out_load=0, wsel=01, waddr=R_I, raddr1=0, raddr2=0.
- Reset mid-program: next cycle is INIT_I; no write happens in the reset cycle. The program reinitialises all three registers before the first compare.
- Latency with step_en held high:
  - 3 init cycles, then 4 cycles per iteration, then 1 final CMP.
  - LIMIT=10 gives 11 iterations; HALT is reached on cycle 48 after reset release.
- le_flag is sampled only in CMP; its value in other states is don't-care.
- Sum arithmetic is in the datapath (8-bit, wraps modulo 256). The controller adds no width checks.

Test Plan:
- Reset release, step_en=1 continuous, bench regfile model with LIMIT=10 -> out_load pulses 11 times with outport 0,1,3,6,10,15,21,28,36,45,55. done rises exactly 48 cycles after reset falls and holds; we never pulses in HALT.
- step_en 1-in-4 duty -> identical write/load sequence; each state lasts 4 cycles; we/out_load are 1-cycle pulses coincident with step_en; total time to done = 192 cycles.
- Assert reset for 1 cycle while in ADD mid-run -> state_dbg=0 next cycle; no we in the reset cycle; rerun again yields final outport 55.
- In HALT, pulse restart with step_en=0 -> no change. Then restart with step_en=1 -> state_dbg 7->0 and the full sequence repeats to 55. restart pulsed during CMP/ADD -> ignored.
- Force le_flag=0 at the first CMP -> HALT on cycle 4, out_load never pulses, outport remains at its reset value.
- Check every state's raddr1/raddr2/waddr/wsel against the table above. wsel=11 is never observed.

Source files
------------

// File: rtl/regfile_seq_ctrl_if.sv
//============================================================================
// Module      : regfile_seq_ctrl_if
// Description : Controller <-> register-file datapath control bundle.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface regfile_seq_ctrl_if #(
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic [ADDR_W-1:0] waddr;
    logic              we;
    logic [1:0]        wsel;
    logic              out_load;
    logic              le_flag;

    modport master (
        output raddr1, raddr2, waddr, we, wsel, out_load,
        input  le_flag
    );

    modport slave (
        input  raddr1, raddr2, waddr, we, wsel, out_load,
        output le_flag
    );
endinterface

`default_nettype wire

// File: rtl/regfile_seq_ctrl.sv
//============================================================================
// Module      : regfile_seq_ctrl
// Description : Moore FSM sequencing the running-sum register-file datapath.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module regfile_seq_ctrl #(
    parameter int ADDR_W = 3,
    parameter int R_I    = 1,
    parameter int R_SUM  = 2,
    parameter int R_ONE  = 3
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic                 step_en,
    input  wire logic                 restart,
    regfile_seq_ctrl_if.master        rf,
    output logic                      done,
    output logic [2:0]                state_dbg
);

    typedef enum logic [2:0] {
        S_INIT_I   = 3'd0,
        S_INIT_SUM = 3'd1,
        S_INIT_ONE = 3'd2,
        S_CMP      = 3'd3,
        S_ADD      = 3'd4,
        S_INC      = 3'd5,
        S_OUT      = 3'd6,
        S_HALT     = 3'd7
    } state_t;

    localparam logic [ADDR_W-1:0] c_ra_i   = ADDR_W'(R_I);
    localparam logic [ADDR_W-1:0] c_ra_sum = ADDR_W'(R_SUM);
    localparam logic [ADDR_W-1:0] c_ra_one = ADDR_W'(R_ONE);
    localparam logic [1:0]        c_wsel_alu  = 2'b00;
    localparam logic [1:0]        c_wsel_zero = 2'b01;
    localparam logic [1:0]        c_wsel_one  = 2'b10;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] w_raddr1;
    logic [ADDR_W-1:0] w_raddr2;
    logic [ADDR_W-1:0] w_waddr;
    logic [1:0]        w_wsel;
    logic              w_we_st;
    logic              w_ld_st;
    logic              w_done;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_INIT_I;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (step_en) begin
            case (r_state)
                S_INIT_I:   w_next = S_INIT_SUM;
                S_INIT_SUM: w_next = S_INIT_ONE;
                S_INIT_ONE: w_next = S_CMP;
                S_CMP:      w_next = rf.le_flag ? S_ADD : S_HALT;
                S_ADD:      w_next = S_INC;
                S_INC:      w_next = S_OUT;
                S_OUT:      w_next = S_CMP;
                S_HALT:     w_next = restart ? S_INIT_I : S_HALT;
                default:    w_next = S_INIT_I;
            endcase
        end
    end

    always_comb begin
        w_raddr1 = '0;
        w_raddr2 = '0;
        w_waddr  = '0;
        w_wsel   = c_wsel_alu;
        w_we_st  = 1'b0;
        w_ld_st  = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            S_INIT_I: begin
                w_waddr = c_ra_i;   w_wsel = c_wsel_zero; w_we_st = 1'b1;
            end
            S_INIT_SUM: begin
                w_waddr = c_ra_sum; w_wsel = c_wsel_zero; w_we_st = 1'b1;
            end
            S_INIT_ONE: begin
                w_waddr = c_ra_one; w_wsel = c_wsel_one;  w_we_st = 1'b1;
            end
            S_CMP: w_raddr1 = c_ra_i;
            S_ADD: begin
                w_raddr1 = c_ra_sum; w_raddr2 = c_ra_i;
                w_waddr  = c_ra_sum; w_we_st  = 1'b1;
            end
            S_INC: begin
                w_raddr1 = c_ra_i; w_raddr2 = c_ra_one;
                w_waddr  = c_ra_i; w_we_st  = 1'b1;
            end
            S_OUT: begin
                w_raddr1 = c_ra_sum; w_ld_st = 1'b1;
            end
            S_HALT: begin
                w_raddr1 = c_ra_sum; w_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes only fire on an enabled step so the slow-tick mode never double-writes.
    assign rf.we       = w_we_st & step_en & ~reset;
    assign rf.out_load = w_ld_st & step_en & ~reset;
    assign rf.raddr1   = w_raddr1;
    assign rf.raddr2   = w_raddr2;
    assign rf.waddr    = w_waddr;
    assign rf.wsel     = w_wsel;
    assign done        = w_done;
    assign state_dbg   = r_state;

endmodule

`default_nettype wire
